// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU (C) and external loader (X).
// Optional: DMEM_ARB_FIXED_PRIO_EN selects fixed CPU priority.
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
);

    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
        $error("dmem_arbiter: RD_LATENCY must be 1..7");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic                  r_owner_x;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic w_arb_ok;
    logic w_pick_c;
    logic w_gnt_c;
    logic w_gnt_x;
    logic w_we;
    logic w_rd_gnt;
    logic w_busy;
    logic w_resp;
    logic w_cpu_out;

    // Gating with rst keeps every output low while reset is held.
    assign w_arb_ok = rst & (r_state != S_WAIT);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_pick_c = cpu_req;
`else
    logic r_last_x;
    assign w_pick_c = cpu_req & (~ext_req | r_last_x);
`endif

    assign w_gnt_c  = w_arb_ok & w_pick_c;
    assign w_gnt_x  = w_arb_ok & ext_req & ~w_pick_c;
    assign w_we     = (w_gnt_c & cpu_we) | (w_gnt_x & ext_we);
    assign w_rd_gnt = (w_gnt_c | w_gnt_x) & ~w_we;
    assign w_busy   = (r_state == S_WAIT);
    assign w_resp   = (r_state == S_RESP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_state_nxt = w_rd_gnt ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (r_cnt == 3'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 3'd0;
            r_owner_x <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_rd_gnt) begin
                r_cnt     <= 3'(RD_LATENCY);
                r_owner_x <= w_gnt_x;
            end else if (w_busy) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    r_rdata <= mem_rd;
                end
            end
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Reset as "X granted last" so the first tie goes to the CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_x <= 1'b1;
        end else if (w_gnt_c | w_gnt_x) begin
            r_last_x <= w_gnt_x;
        end
    end
`endif

    assign cpu_gnt    = w_gnt_c;
    assign ext_gnt    = w_gnt_x;
    assign mem_en     = w_gnt_c | w_gnt_x;
    assign mem_we     = w_we;
    assign mem_addr   = w_gnt_c ? cpu_addr  : (w_gnt_x ? ext_addr  : '0);
    assign mem_wd     = w_gnt_c ? cpu_wdata : (w_gnt_x ? ext_wdata : '0);
    assign cpu_rvalid = w_resp & ~r_owner_x;
    assign ext_rvalid = w_resp & r_owner_x;
    assign cpu_rdata  = r_rdata;
    assign ext_rdata  = r_rdata;
    assign busy       = w_busy;

    assign w_cpu_out = (w_gnt_c & ~cpu_we) | (w_busy & ~r_owner_x);
    assign cpu_stall = rst & ((cpu_req & ~w_gnt_c)
                     | (w_cpu_out & ~cpu_rvalid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter at RD_LATENCY 1 (u_a) and 3 (u_b).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;

    logic        a_cgnt, a_crv, a_stall, a_xgnt, a_xrv;
    logic        a_en, a_we, a_busy;
    logic [31:0] a_crd, a_xrd, a_addr, a_wd, a_rd;
    logic        b_cgnt, b_crv, b_stall, b_xgnt, b_xrv;
    logic        b_en, b_we, b_busy;
    logic [31:0] b_crd, b_xrd, b_addr, b_wd, b_rd;

    logic [31:0] mem_a [16];
    logic [31:0] mem_b [16];
    logic [31:0] qa, qb0, qb1, qb2;

    int n_chk = 0;
    int n_fail = 0;
    logic [3:0] exp_c;

    always #5 clk = ~clk;

    dmem_arbiter #(.RD_LATENCY(1)) u_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(a_cgnt), .cpu_rvalid(a_crv),
        .cpu_rdata(a_crd), .cpu_stall(a_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(a_xgnt), .ext_rvalid(a_xrv), .ext_rdata(a_xrd),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wd(a_wd), .mem_rd(a_rd), .busy(a_busy)
    );

    dmem_arbiter #(.RD_LATENCY(3)) u_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(b_cgnt), .cpu_rvalid(b_crv),
        .cpu_rdata(b_crd), .cpu_stall(b_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(b_xgnt), .ext_rvalid(b_xrv), .ext_rdata(b_xrd),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wd(b_wd), .mem_rd(b_rd), .busy(b_busy)
    );

    // Memory models: 1-cycle and 3-cycle read pipelines.
    always @(posedge clk) begin
        if (a_en) begin
            if (a_we) mem_a[a_addr[5:2]] <= a_wd;
            else      qa <= mem_a[a_addr[5:2]];
        end
    end
    assign a_rd = qa;

    always @(posedge clk) begin
        qb1 <= qb0;
        qb2 <= qb1;
        if (b_en) begin
            if (b_we) mem_b[b_addr[5:2]] <= b_wd;
            else      qb0 <= mem_b[b_addr[5:2]];
        end
    end
    assign b_rd = qb2;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_c(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drv_x(input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        ext_req = r; ext_we = w; ext_addr = a; ext_wdata = d;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b0;
        drv_c(0, 0, 0, 0);
        drv_x(0, 0, 0, 0);
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drv_c(0, 0, 0, 0);
        drv_x(0, 0, 0, 0);
        #2;
        check("rst_busy", a_busy, 0);
        check("rst_en", a_en, 0);
        check("rst_stall", a_stall, 0);
        check("rst_rdata", a_crd, 0);
        check("rst_cgnt", a_cgnt, 0);

        // Single CPU write
        cyc();
        rst = 1'b1;
        drv_c(1, 1, 32'h10, 32'hDEADBEEF);
        #1;
        check("wr_gnt", a_cgnt, 1);
        check("wr_en", a_en, 1);
        check("wr_we", a_we, 1);
        check("wr_addr", a_addr, 32'h10);
        check("wr_wd", a_wd, 32'hDEADBEEF);
        check("wr_stall", a_stall, 0);
        check("wr_xgnt", a_xgnt, 0);
        cyc();
        drv_c(0, 0, 0, 0);
        #1;
        check("wr_idle_busy", a_busy, 0);
        check("wr_idle_en", a_en, 0);

        // CPU read, latency 1
        cyc();
        drv_c(1, 0, 32'h10, 0);
        #1;
        check("rd_gnt", a_cgnt, 1);
        check("rd_en", a_en, 1);
        check("rd_we", a_we, 0);
        check("rd_stall0", a_stall, 1);
        cyc();
        drv_c(0, 0, 0, 0);
        #1;
        check("rd_busy", a_busy, 1);
        check("rd_stall1", a_stall, 1);
        check("rd_rv_early", a_crv, 0);
        check("rd_wait_en", a_en, 0);
        cyc();
        #1;
        check("rd_rv", a_crv, 1);
        check("rd_data", a_crd, 32'hDEADBEEF);
        check("rd_stall2", a_stall, 0);
        check("rd_xrv", a_xrv, 0);
        cyc();
        #1;
        check("rd_rv_off", a_crv, 0);
        check("rd_hold", a_crd, 32'hDEADBEEF);

        // Simultaneous writes: arbitration order
        do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_c = 4'b1111;
`else
        exp_c = 4'b0101;
`endif
        drv_c(1, 1, 32'h24, 32'h22222222);
        drv_x(1, 1, 32'h20, 32'h11111111);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_cgnt%0d", i), a_cgnt, exp_c[i]);
            check($sformatf("rr_xgnt%0d", i), a_xgnt, !exp_c[i]);
            check($sformatf("rr_addr%0d", i), a_addr,
                  exp_c[i] ? 32'h24 : 32'h20);
            check($sformatf("rr_b_cgnt%0d", i), b_cgnt, exp_c[i]);
            cyc();
        end
        drv_c(0, 0, 0, 0);
        drv_x(0, 0, 0, 0);

        // External read at latency 3 with CPU waiting
        do_reset();
        drv_x(1, 1, 32'h28, 32'h0BADF00D);
        #1;
        check("x_wr_gnt", b_xgnt, 1);
        cyc();
        drv_x(1, 0, 32'h28, 0);
        #1;
        check("x_rd_gnt", b_xgnt, 1);
        check("x_rd_stall", b_stall, 0);
        cyc();
        drv_x(0, 0, 0, 0);
        drv_c(1, 1, 32'h30, 32'h33);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("x_w_cgnt%0d", k), b_cgnt, 0);
            check($sformatf("x_w_stall%0d", k), b_stall, 1);
            check($sformatf("x_w_busy%0d", k), b_busy, 1);
            check($sformatf("x_w_xrv%0d", k), b_xrv, 0);
            cyc();
        end
        #1;
        check("x_rv", b_xrv, 1);
        check("x_rdata", b_xrd, 32'h0BADF00D);
        check("x_resp_cgnt", b_cgnt, 1);
        check("x_resp_stall", b_stall, 0);
        check("x_resp_crv", b_crv, 0);
        cyc();
        drv_c(0, 0, 0, 0);

        // Reset mid-WAIT
        cyc();
        drv_x(1, 0, 32'h28, 0);
        #1;
        check("mr_gnt", b_xgnt, 1);
        cyc();
        drv_x(0, 0, 0, 0);
        #1;
        check("mr_busy", b_busy, 1);
        cyc();
        rst = 1'b0;
        drv_c(1, 1, 32'h34, 32'h1);
        drv_x(1, 1, 32'h38, 32'h2);
        #1;
        check("mr_r_busy", b_busy, 0);
        check("mr_r_en", b_en, 0);
        check("mr_r_cgnt", b_cgnt, 0);
        check("mr_r_xgnt", b_xgnt, 0);
        check("mr_r_stall", b_stall, 0);
        check("mr_r_rdata", b_xrd, 0);
        check("mr_r_addr", b_addr, 0);
        cyc();
        rst = 1'b1;
        #1;
        check("mr_tie_c", b_cgnt, 1);
        check("mr_tie_x", b_xgnt, 0);
        check("mr_busy0", b_busy, 0);
        cyc();
        drv_c(0, 0, 0, 0);
        drv_x(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("mr_xrv%0d", k), b_xrv, 0);
            check($sformatf("mr_crv%0d", k), b_crv, 0);
            check($sformatf("mr_bsy%0d", k), b_busy, 0);
            cyc();
        end

        // Back-to-back CPU reads, latency 1
        drv_c(1, 1, 32'h40, 32'hA5A5A5A5);
        cyc();
        drv_c(1, 1, 32'h44, 32'h5A5A5A5A);
        cyc();
        drv_c(1, 0, 32'h40, 0);
        #1;
        check("bb_g1", a_cgnt, 1);
        cyc();
        drv_c(0, 0, 0, 0);
        #1;
        check("bb_w_gnt", a_cgnt, 0);
        check("bb_w_rv", a_crv, 0);
        cyc();
        drv_c(1, 0, 32'h44, 0);
        #1;
        check("bb_rv1", a_crv, 1);
        check("bb_d1", a_crd, 32'hA5A5A5A5);
        check("bb_g2", a_cgnt, 1);
        check("bb_addr2", a_addr, 32'h44);
        cyc();
        drv_c(0, 0, 0, 0);
        #1;
        check("bb_w2_rv", a_crv, 0);
        check("bb_w2_busy", a_busy, 1);
        check("bb_w2_stall", a_stall, 1);
        cyc();
        #1;
        check("bb_rv2", a_crv, 1);
        check("bb_d2", a_crd, 32'h5A5A5A5A);
        check("bb_stall", a_stall, 0);
        cyc();
        #1;
        check("bb_rv_off", a_crv, 0);
        check("bb_hold", a_crd, 32'h5A5A5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
